// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 10110 sequence detector.
// Words arrive on a valid/ready handshake and leave one bit per enabled clock on x.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next_bit;
  logic [CNT_W-1:0] bit_cnt;
  logic             in_shift;
  logic             last_bit;
  logic             load;

  assign in_shift  = (state == ST_SHIFT);
  assign last_bit  = in_shift && (bit_cnt == LAST_CNT);

  // The reset term keeps the source from seeing ready while reset is held.
  assign din_ready = reset && ((state == ST_IDLE) || (last_bit && shift_en));
  assign word_done = last_bit && shift_en;
  assign load      = din_valid && din_ready;
  assign x_valid   = in_shift;

  always_comb begin
    if (MSB_FIRST) begin
      shreg_next_bit = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_next_bit = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    x = IDLE_BIT;
    if (in_shift) begin
      x = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
  end

  // A reload on the last bit goes straight to the new word's first bit, so
  // back-to-back words stream without an idle bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_SHIFT;
            shreg   <= din;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (last_bit) begin
              if (load) begin
                shreg   <= din;
                bit_cnt <= '0;
              end else begin
                state   <= ST_IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
              end
            end else begin
              shreg   <= shreg_next_bit;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          shreg   <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
